// File: rtl/key_input_pkg.sv
// Shared types and defaults for the key input front end.
// Per-channel FSM states, parameter defaults and timer sizing.
package key_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REPEAT
  } key_state_t;

  localparam int N_KEYS_DEF = 4;
  localparam logic ACTIVE_LOW_DEF = 1'b1;
  localparam int DEBOUNCE_DEF = 4;
  localparam int HOLD_DEF = 10;
  localparam int REPEAT_DEF = 3;

  function automatic int tmr_width(
    input int hold,
    input int rep
  );
    return $clog2((hold > rep) ? hold : rep) + 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: two-flop sync, debounce, repeat FSM and
// registered press/release/held outputs.
module key_channel
  import key_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int REPEAT_CYCLES = REPEAT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic key,
  input  logic rep_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic held
);

  localparam int TW = tmr_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_CYCLES - 1);

  logic s1, s2, stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  key_state_t state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic press_d, rel_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      timer <= '0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      held <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      press_pulse <= press_d;
      release_pulse <= rel_d;
      held <= stable;
    end
  end

  // Release is checked first so it always wins over a repeat.
  always_comb begin
    state_d = state;
    timer_d = timer;
    press_d = 1'b0;
    rel_d = 1'b0;
    unique case (state)
      IDLE: begin
        timer_d = '0;
        if (stable) begin
          press_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!stable) begin
          rel_d = 1'b1;
          state_d = IDLE;
          timer_d = '0;
        end else if (!rep_en) begin
          timer_d = '0;
        end else if (timer == HOLD_LAST) begin
          press_d = 1'b1;
          state_d = REPEAT;
          timer_d = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      REPEAT: begin
        if (!stable) begin
          rel_d = 1'b1;
          state_d = IDLE;
          timer_d = '0;
        end else if (!rep_en) begin
          state_d = WAIT;
          timer_d = '0;
        end else if (timer == REP_LAST) begin
          press_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_pulse_array.sv
// Array of independent key channels with input polarity
// normalisation so that internally 1 always means pressed.
module key_pulse_array
  import key_input_pkg::*;
#(
  parameter int N_KEYS = N_KEYS_DEF,
  parameter logic ACTIVE_LOW = ACTIVE_LOW_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int REPEAT_CYCLES = REPEAT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] in,
  input  logic [N_KEYS-1:0] rep_en,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] held
);

  logic [N_KEYS-1:0] key;

  assign key = in ^ {N_KEYS{ACTIVE_LOW}};

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .CLK(CLK),
      .RST(RST),
      .key(key[i]),
      .rep_en(rep_en[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .held(held[i])
    );
  end

endmodule

// File: tb/tb_key_pulse_array.sv
// Scoreboard bench for key_pulse_array: directed scenarios then
// random key activity, checked against a behavioural model.
module tb_key_pulse_array;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [3:0] in_r = 4'hF;
  logic [3:0] rep_en = 4'h0;
  logic [3:0] press_pulse, release_pulse, held;

  always #5 CLK = ~CLK;

  key_pulse_array #(
    .N_KEYS(4),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .in(in_r),
    .rep_en(rep_en),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .held(held)
  );

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] h;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: sync pipeline, accepted level, run of differing
  // samples, held output, enabled-cycle run and hold/repeat phase.
  bit m_s1[4], m_s2[4], m_stb[4], m_hld[4], m_first[4];
  int m_run[4], m_en[4];

  task automatic step(input logic [3:0] kin, input logic [3:0] ren,
                      input logic rst);
    exp_t e;
    @(negedge CLK);
    in_r = kin;
    rep_en = ren;
    RST = rst;
    e = '0;
    for (int c = 0; c < 4; c++) begin
      if (!rst) begin
        m_s1[c] = 0; m_s2[c] = 0; m_stb[c] = 0; m_hld[c] = 0;
        m_run[c] = 0; m_en[c] = 0; m_first[c] = 1;
      end else begin
        e.h[c] = m_stb[c];
        if (!m_hld[c] && m_stb[c]) begin
          e.p[c] = 1'b1;
          m_en[c] = 0;
          m_first[c] = 1;
        end else if (m_hld[c] && !m_stb[c]) begin
          e.r[c] = 1'b1;
        end else if (m_hld[c]) begin
          if (!ren[c]) begin
            m_en[c] = 0;
            m_first[c] = 1;
          end else begin
            m_en[c]++;
            if (m_en[c] == (m_first[c] ? H : R)) begin
              e.p[c] = 1'b1;
              m_en[c] = 0;
              m_first[c] = 0;
            end
          end
        end
        m_hld[c] = m_stb[c];
        if (m_s2[c] != m_stb[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_stb[c] = ~m_stb[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = ~kin[c];
      end
    end
    q.push_back(e);
  endtask

  task automatic hold(input logic [3:0] kin, input logic [3:0] ren,
                      input int n);
    for (int k = 0; k < n; k++) step(kin, ren, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({press_pulse, release_pulse, held} !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got p=%b r=%b h=%b exp p=%b r=%b h=%b",
                   cyc, press_pulse, release_pulse, held, e.p, e.r, e.h);
        end
      end
    end
  end

  logic [3:0] cur_in;
  logic [3:0] cur_rep;

  initial begin
    step(4'hF, 4'h0, 1'b0);
    step(4'hF, 4'h0, 1'b0);
    hold(4'hF, 4'h0, 3);
    // single press and release on channel 0
    hold(4'hE, 4'h0, 15);
    hold(4'hF, 4'h0, 12);
    // bouncing channel 1
    for (int k = 0; k < 5; k++) begin
      hold(4'hD, 4'h0, 2);
      hold(4'hF, 4'h0, 2);
    end
    hold(4'hF, 4'h0, 10);
    // long hold with auto-repeat on channel 2
    hold(4'hB, 4'h4, 37);
    hold(4'hF, 4'h4, 14);
    // hold without repeat, then enable repeat mid-hold
    hold(4'hB, 4'h0, 30);
    hold(4'hB, 4'h4, 20);
    hold(4'hF, 4'h0, 14);
    // all channels pressed together
    hold(4'h0, 4'h0, 12);
    hold(4'hF, 4'h0, 12);
    // reset while channel 3 repeats, key kept held
    hold(4'h7, 4'h8, 25);
    step(4'h7, 4'h8, 1'b0);
    step(4'h7, 4'h8, 1'b0);
    hold(4'h7, 4'h8, 20);
    hold(4'hF, 4'h0, 12);
    // random activity
    cur_in = 4'hF;
    cur_rep = 4'h0;
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(c < 2 ? 7 : 40) == 0) cur_in[c] = ~cur_in[c];
      end
      if ($urandom_range(31) == 0) cur_rep = 4'($urandom);
      step(cur_in, cur_rep, ($urandom_range(249) == 0) ? 1'b0 : 1'b1);
    end
    hold(4'hF, 4'h0, 12);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_pulse_array.md
Name: key_pulse_array

Overview:
- Parametrised multi-channel successor to the single-key pulse generator.
- Each of N_KEYS raw button inputs is synchronised, debounced and converted to one-cycle press/release pulses.
- Optional hold-to-auto-repeat on press_pulse, so a held direction key moves the ship continuously.
- Sits between board KEY/SW pins and game control logic; all outputs are in the CLK domain.

Parameters:
- N_KEYS, 4, number of independent channels.
- ACTIVE_LOW, 1, 1 = raw input low means pressed (DE1 KEYs); 0 = high means pressed.
- DEBOUNCE_CYCLES, 4, consecutive cycles a new level must persist before it is accepted; legal range >=1.
- HOLD_CYCLES, 10, cycles from the initial press pulse to the first repeat pulse; >=2.
- REPEAT_CYCLES, 3, cycles between successive repeat pulses; >=2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-low; all state is cleared on a CLK edge while RST==0.
- in  in  N_KEYS  raw asynchronous key levels.
- rep_en  in  N_KEYS  per-channel auto-repeat enable; synchronous.
- press_pulse  out  N_KEYS  one-cycle pulse on each accepted press and on each repeat.
- release_pulse  out  N_KEYS  one-cycle pulse on each accepted release.
- held  out  N_KEYS  debounced pressed level.

Behaviour:
- Reset (RST==0 at an edge):
  - Sync flops, stable level, counters and all outputs go to 0, i.e. the released state.
  - State goes to IDLE.
  - A key held through reset is seen as a new press after RST deasserts, with full latency.
- Polarity: the input is XORed with ACTIVE_LOW before the synchroniser, so internally 1 means pressed.
- Synchroniser: two flops per channel (s1, s2).
- Debounce:
  - The counter increments each cycle that s2 differs from the stable level, and clears when they match.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, stable toggles at that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (after sync) never changes stable.
- Output stage: held, press_pulse and release_pulse are registered, one edge after the stable update.
- Latency: raw level changes before edge 1 and stays steady. held rises and press_pulse pulses after edge DEBOUNCE_CYCLES+3. Release has the same latency.
- Per-channel FSM, with a timer of width $clog2(max(HOLD,REPEAT))+1:
  - IDLE: on stable 0->1, emit press_pulse and go to WAIT with the timer cleared.
  - WAIT: on release, emit release_pulse and go to IDLE. Else, if rep_en==1, the timer increments. When the timer reaches HOLD_CYCLES-1, emit press_pulse and go to REPEAT with the timer cleared. If rep_en==0, the timer holds at 0.
  - REPEAT: on release, emit release_pulse and go to IDLE. If rep_en==0, go to WAIT with the timer at 0. Else the timer counts, and at REPEAT_CYCLES-1 it emits press_pulse and clears.
- Release has priority: press_pulse and release_pulse are never high together on one channel.
- Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.
- Press pulse count from one long hold with rep_en=1: 1 + 1 + floor((T - HOLD_CYCLES - 1)/REPEAT_CYCLES), where T is the held cycle count measured from the initial pulse.

Decomposition:
- Package key_input_pkg:
  - enum key_state_t {IDLE, WAIT, REPEAT}.
  - Default parameter constants.
  - Function to compute timer width.
- Sub-module key_channel: one synchroniser, debouncer, FSM and output register set per channel.
- key_pulse_array instantiates N_KEYS copies in a generate loop, and applies polarity and fan-out.

Test Plan (N_KEYS=4, ACTIVE_LOW=1, DEBOUNCE=4, HOLD=10, REPEAT=3):
- Reset, then drive in[0]=0 steady -> held[0]=1 and a single press_pulse[0] exactly 7 edges later. in[0]=1 steady -> release_pulse[0] exactly 7 edges later.
- Bounce in[1]: 2-cycle low pulses separated by 2 cycles high, repeated 5 times -> held, press_pulse and release_pulse stay 0.
- in[2]=0 held for 30 cycles after the initial pulse, rep_en[2]=1 -> press_pulses at t0, t0+10, t0+13, t0+16, ... up to release. No press_pulse after release_pulse.
- Same hold with rep_en[2]=0 -> exactly one press_pulse. Raise rep_en mid-hold -> first repeat comes 10 cycles after enable.
- Press all four channels on the same edge -> all four press_pulse bits high in one cycle.
- Pull RST low while in[3] is held in REPEAT -> outputs 0 on the next edge. Release RST with the key still held -> a fresh press_pulse 7 edges later.
